fetch_unit: RTL and testbench

- Instruction fetch stage that sits directly upstream of the word-aligned, combinational-read instruction memory.
- Owns the PC register and drives the memory address.
- Captures each returned instruction word together with its PC into a small buffer.
- Presents fetched instructions to decode over a valid/ready handshake, and accepts branch/jump redirects from execute.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_buf.sv | 63 ++++++
 rtl/fetch_unit.sv | 85 ++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and constants.
// The fetch buffer stores one fetch_entry_t for each instruction word it accepts.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetch entries. The head is registered and the output has zero-cycle latency.
// Flush has priority over push and pop. The caller must not push when the FIFO is full unless it also pops.
module fetch_buf
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_dat_i,
    input  logic          pop_i,
    output fetch_entry_t  head_dat_o,
    output logic          head_vld_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push_i && !pop_i)      count_d = count_q + CW'(1);
            else if (pop_i && !push_i) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // The storage has no reset because its contents are qualified by count_q.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign head_vld_o = (count_q != '0);
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: the PC register, the fetch buffer, redirect handling, and sticky error flags.
// An instruction becomes visible one cycle after it is fetched. When out_ready is low the buffer fills and the PC then holds.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              IMEM_WORDS = 64,
    parameter int              BUF_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic            misalign_err,
    output logic            range_err
);

    localparam int              CW       = $clog2(BUF_DEPTH) + 1;
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_WORDS * INSTR_BYTES);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            range_q, range_d;
    logic            range_hit, full, pop, push;
    logic [CW-1:0]   count;
    fetch_entry_t    head, wr_entry;

    assign range_hit = (pc_q >= PC_LIMIT);
    assign full      = (count == CW'(BUF_DEPTH));
    assign pop       = out_valid && out_ready;
    assign push      = !redirect_valid && !range_hit && (!full || pop);
    assign wr_entry  = '{pc: pc_q, instr: imem_rdata};

    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        range_d    = range_q || range_hit;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (push) begin
            pc_d = pc_q + XLEN'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            range_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            range_q    <= range_d;
        end
    end

    // A redirect flushes the buffer. This also absorbs any pop in the same cycle.
    fetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush_i    (redirect_valid),
        .push_i     (push),
        .push_dat_i (wr_entry),
        .pop_i      (pop),
        .head_dat_o (head),
        .head_vld_o (out_valid),
        .count_o    (count)
    );

    assign imem_addr    = pc_q;
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign out_pc_plus4 = head.pc + XLEN'(INSTR_BYTES);
    assign misalign_err = misalign_q;
    assign range_err    = range_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam int MEMW = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_pc_plus4;
    logic        misalign_err, range_err;

    logic [31:0] mem [MEMW];
    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr[7:2]];

    fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(MEMW), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .misalign_err   (misalign_err),
        .range_err      (range_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is an ordered queue bounded at two entries.
    fetch_entry_t mq[$];
    logic [31:0]  m_pc;
    logic         m_mis, m_rng;
    bit           m_live = 0;

    always @(posedge clk) begin
        if (!reset_n) begin
            mq.delete();
            m_pc   = 32'h0;
            m_mis  = 0;
            m_rng  = 0;
            m_live = 1;
        end else if (m_live) begin
            automatic bit hit = (m_pc >= 32'(MEMW * 4));
            automatic bit pop = (mq.size() != 0) && out_ready;
            automatic int sz  = mq.size();
            if (hit) m_rng = 1;
            if (redirect_valid) begin
                mq.delete();
                m_pc = redirect_pc & ~32'h3;
                if (redirect_pc % 4 != 0) m_mis = 1;
            end else begin
                if (pop) void'(mq.pop_front());
                if (!hit && (sz < 2 || pop)) begin
                    mq.push_back('{pc: m_pc, instr: mem[m_pc / 4]});
                    m_pc = m_pc + 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
            chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
            chk("range_err", {31'b0, range_err}, {31'b0, m_rng});
            if (mq.size() != 0) begin
                chk("out_pc", out_pc, mq[0].pc);
                chk("out_instr", out_instr, mq[0].instr);
                chk("out_pc_plus4", out_pc_plus4, mq[0].pc + 32'd4);
            end
        end
    end

    task automatic redirect_at(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < MEMW; k++) mem[k] = 32'h1000_0000 + k;
        reset_n = 0; out_ready = 1; redirect_valid = 0; redirect_pc = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;

        // Reset state, then four back-to-back outputs.
        @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_flags", {30'b0, misalign_err, range_err}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("seq_pc", out_pc, 32'(4 * k));
            chk("seq_instr", out_instr, 32'h1000_0000 + 32'(k));
            chk("seq_plus4", out_pc_plus4, 32'(4 * k + 4));
        end

        // Backpressure after a fresh reset.
        reset_n = 0; out_ready = 0;
        @(posedge clk); #1 reset_n = 1;
        repeat (6) @(negedge clk);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_head", out_pc, 32'h0);
        chk("bp_addr", imem_addr, 32'h8);
        out_ready = 1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            chk("bp_drain_pc", out_pc, 32'(4 * k));
        end

        // Redirect while two entries are buffered.
        redirect_at(32'h20);
        chk("rd_valid", {31'b0, out_valid}, 32'd0);
        chk("rd_addr", imem_addr, 32'h20);
        @(negedge clk);
        chk("rd_pc", out_pc, 32'h20);
        chk("rd_instr", out_instr, 32'h1000_0008);

        // A misaligned target is aligned down and sets the sticky flag.
        redirect_at(32'h22);
        chk("mis_addr", imem_addr, 32'h20);
        chk("mis_flag", {31'b0, misalign_err}, 32'd1);
        repeat (5) @(negedge clk);
        chk("mis_sticky", {31'b0, misalign_err}, 32'd1);

        // Run off the end of memory, then recover with a redirect.
        redirect_at(32'hE0);
        begin
            int t = 0;
            while (!range_err && t < 60) begin @(negedge clk); t++; end
            chk("range_set", {31'b0, range_err}, 32'd1);
        end
        chk("range_addr", imem_addr, 32'h100);
        repeat (3) @(negedge clk);
        chk("range_stall", imem_addr, 32'h100);
        chk("range_empty", {31'b0, out_valid}, 32'd0);
        redirect_at(32'h0);
        @(negedge clk);
        chk("resume_pc", out_pc, 32'h0);
        chk("resume_instr", out_instr, 32'h1000_0000);
        chk("range_sticky", {31'b0, range_err}, 32'd1);

        // Mid-stream reset with a full buffer.
        out_ready = 0;
        repeat (4) @(negedge clk);
        reset_n = 0;
        @(negedge clk);
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_flags", {30'b0, misalign_err, range_err}, 32'd0);
        chk("mrst_addr", imem_addr, 32'h0);
        reset_n = 1; out_ready = 1;
        @(negedge clk);
        chk("mrst_pc", out_pc, 32'h0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
